// File: rtl/lsu_sram_ctrl_if.sv
// Request/response handshake between the execute stage (master) and the
// load/store unit (slave). Widths follow the unit's DATA_W / ADDR_W.
interface lsu_sram_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_ale;

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_ale
  );

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_ale
  );
endinterface

// File: rtl/lsu_sram_ctrl.sv
// lsu_sram_ctrl: load/store unit between the execute stage and the data SRAM.
// One transaction in flight; FSM IDLE -> ACCESS -> (WAIT) -> RESP.
// Byte strobes and lane-replicated store data, sign/zero-extended loads,
// RD_LAT-cycle SRAM read latency.
// Optional feature macro: LSU_ALE_EN (misaligned accesses return resp_ale=1
// without touching the SRAM; when undefined the address is naturally aligned
// and the access proceeds).
module lsu_sram_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  lsu_sram_ctrl_if.slave      lsu,
  output logic                data_sram_en_o,
  output logic [DATA_W/8-1:0] data_sram_we_o,
  output logic [ADDR_W-1:0]   data_sram_addr_o,
  output logic [DATA_W-1:0]   data_sram_wdata_o,
  input  logic [DATA_W-1:0]   data_sram_rdata_i
);

  localparam int         NB       = DATA_W / 8;
  localparam int         OFF_W    = $clog2(NB);
  localparam logic [1:0] MAX_SIZE = 2'(OFF_W);
  localparam logic [2:0] LAT      = 3'(RD_LAT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Mask of the address bits that must be zero for a naturally aligned access.
  function automatic logic [OFF_W-1:0] size_mask(input logic [1:0] size);
    logic [OFF_W-1:0] m;
    m = '0;
    for (int i = 0; i < OFF_W; i++) begin
      m[i] = (i < int'(size));
    end
    return m;
  endfunction

  // Byte strobes: 2^size consecutive lanes starting at the byte offset.
  function automatic logic [NB-1:0] byte_strobe(input logic [1:0] size,
                                                input logic [OFF_W-1:0] off);
    logic [NB-1:0] s;
    int            n;
    n = 32'sd1 << size;
    for (int i = 0; i < NB; i++) begin
      s[i] = (i >= int'(off)) && (i < (int'(off) + n));
    end
    return s;
  endfunction

  // Replicate the low 2^size bytes of the store data across every lane.
  function automatic logic [DATA_W-1:0] replicate(input logic [1:0] size,
                                                  input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] r;
    int                n;
    n = 32'sd1 << size;
    for (int i = 0; i < NB; i++) begin
      r[8*i +: 8] = wd[8*(i & (n - 32'sd1)) +: 8];
    end
    return r;
  endfunction

  // Keep the low 2^size bytes and sign- or zero-extend to the full width.
  function automatic logic [DATA_W-1:0] extend(input logic [1:0] size,
                                               input logic uns,
                                               input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    logic              fill;
    int                nbits;
    nbits = 32'sd8 << size;
    fill  = uns ? 1'b0 : d[nbits-1];
    for (int b = 0; b < DATA_W; b++) begin
      r[b] = (b < nbits) ? d[b] : fill;
    end
    return r;
  endfunction

  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [ADDR_W-1:0] saddr_q, saddr_d;
  logic [NB-1:0]     we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ale_q, ale_d;
  logic [2:0]        cnt_q, cnt_d;

  logic [1:0]        size_eff_s;
  logic [OFF_W-1:0]  low_s;
  logic [OFF_W-1:0]  off_s;
  logic              ale_s;
  logic [DATA_W-1:0] shifted_s;

  // Decode the incoming request: clamp size, compute offset and alignment error.
  always_comb begin
    size_eff_s = (lsu.req_size > MAX_SIZE) ? MAX_SIZE : lsu.req_size;
    low_s      = lsu.req_addr[OFF_W-1:0];
`ifdef LSU_ALE_EN
    off_s      = low_s;
    ale_s      = |(low_s & size_mask(size_eff_s));
`else
    off_s      = low_s & ~size_mask(size_eff_s);
    ale_s      = 1'b0;
`endif
  end

  // Right-justify the addressed bytes of the SRAM word (shift at full width).
  always_comb begin
    shifted_s = data_sram_rdata_i >> {off_q, 3'b000};
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (lsu.req_valid) begin
          state_d = ale_s ? S_RESP : S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (store_q) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (lsu.resp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: latch request, arm latency counter, capture load data.
  always_comb begin
    store_d = store_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    saddr_d = saddr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ale_d   = ale_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (lsu.req_valid) begin
          store_d = lsu.req_store;
          size_d  = size_eff_s;
          uns_d   = lsu.req_unsigned;
          off_d   = off_s;
          saddr_d = {lsu.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          we_d    = lsu.req_store ? byte_strobe(size_eff_s, off_s) : {NB{1'b0}};
          wdata_d = lsu.req_store ? replicate(size_eff_s, lsu.req_wdata) : {DATA_W{1'b0}};
          rdata_d = {DATA_W{1'b0}};
          ale_d   = ale_s;
          cnt_d   = 3'd0;
        end else begin
          cnt_d   = 3'd0;
        end
      end
      S_ACCESS: begin
        if (store_q) begin
          cnt_d = 3'd0;
        end else begin
          cnt_d = LAT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = extend(size_q, uns_q, shifted_s);
        end else begin
          rdata_d = rdata_q;
        end
      end
      S_RESP: begin
        cnt_d = 3'd0;
      end
      default: begin
        cnt_d = 3'd0;
      end
    endcase
  end

  // Datapath registers; reset clears everything so an aborted access leaves no trace.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_q <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      off_q   <= {OFF_W{1'b0}};
      saddr_q <= {ADDR_W{1'b0}};
      we_q    <= {NB{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
      ale_q   <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      store_q <= store_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      saddr_q <= saddr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ale_q   <= ale_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded purely from registered state; SRAM strobes live only in ACCESS.
  // Without LSU_ALE_EN ale_q can never be set, so resp_ale stays 0.
  always_comb begin
    lsu.req_ready     = 1'b0;
    lsu.resp_valid    = 1'b0;
    data_sram_en_o    = 1'b0;
    data_sram_we_o    = {NB{1'b0}};
    data_sram_addr_o  = {ADDR_W{1'b0}};
    data_sram_wdata_o = {DATA_W{1'b0}};
    case (state_q)
      S_IDLE: begin
        lsu.req_ready = 1'b1;
      end
      S_ACCESS: begin
        data_sram_en_o    = 1'b1;
        data_sram_we_o    = we_q;
        data_sram_addr_o  = saddr_q;
        data_sram_wdata_o = wdata_q;
      end
      S_WAIT: begin
        lsu.req_ready = 1'b0;
      end
      S_RESP: begin
        lsu.resp_valid = 1'b1;
      end
      default: begin
        lsu.req_ready = 1'b0;
      end
    endcase
    lsu.resp_rdata = rdata_q;
    lsu.resp_ale   = ale_q;
  end

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// Testbench for lsu_sram_ctrl (DATA_W=32, RD_LAT=3) with a byte-strobed SRAM
// model. Expectations follow LSU_ALE_EN when defined.
module tb_lsu_sram_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int RD_LAT = 3;
  localparam int NB     = DATA_W / 8;

  typedef struct {
    logic        store;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ale;
    logic        exp_en;
    logic [3:0]  exp_we;
    logic [31:0] exp_saddr;
    logic [31:0] exp_swdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        sram_en;
  logic [NB-1:0] sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int total = 0;
  int bad   = 0;

  vec_t vecs[17];
  vec_t exp_q[$];

  logic [31:0] mem [64];
  logic [31:0] rd_pipe [RD_LAT];

  always #5 clk = ~clk;

  lsu_sram_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  lsu_sram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk               (clk),
    .reset             (reset),
    .lsu               (bus),
    .data_sram_en_o    (sram_en),
    .data_sram_we_o    (sram_we),
    .data_sram_addr_o  (sram_addr),
    .data_sram_wdata_o (sram_wdata),
    .data_sram_rdata_i (sram_rdata)
  );

  // SRAM model: preload under reset, byte-strobed writes, RD_LAT-stage read pipe.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h8899AABB;
      mem[1] <= 32'h11223344;
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= 32'h5A5A5A5A;
    end else begin
      if (sram_en) begin
        for (int b = 0; b < NB; b++) begin
          if (sram_we[b]) mem[sram_addr[7:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
      end
      rd_pipe[0] <= sram_en ? mem[sram_addr[7:2]] : 32'h5A5A5A5A;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign sram_rdata = rd_pipe[RD_LAT-1];

  function automatic vec_t mk(input logic st, input logic [1:0] sz, input logic un,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input logic eale, input logic een,
                              input logic [3:0] ewe, input logic [31:0] esa,
                              input logic [31:0] esw);
    vec_t v;
    v.store = st; v.size = sz; v.uns = un; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_ale = eale; v.exp_en = een; v.exp_we = ewe;
    v.exp_saddr = esa; v.exp_swdata = esw;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request, follow it to the response, hold resp_ready low for 'hold' cycles.
  task automatic do_txn(input string tag, input vec_t v, input int hold);
    int          lat;
    int          en_seen;
    int          exp_lat;
    vec_t        e;
    logic [31:0] held;
    @(negedge clk);
    check({tag, "_req_ready_idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_store    = v.store;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.resp_ready   = (hold == 0);
    exp_q.push_back(v);
    @(posedge clk);
    lat = 0;
    en_seen = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      if (sram_en) begin
        en_seen++;
        check({tag, "_we"}, 32'(sram_we), 32'(v.exp_we));
        check({tag, "_saddr"}, sram_addr, v.exp_saddr);
        check({tag, "_swdata"}, sram_wdata, v.exp_swdata);
      end
      if (bus.resp_valid) lat = k;
      else check({tag, "_req_ready_busy"}, 32'(bus.req_ready), 32'd0);
    end
    if (lat == 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no resp_valid expected one within 40 cycles", tag);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      bus.resp_ready = 1'b1;
      return;
    end
    exp_lat = v.exp_ale ? 1 : (v.store ? 2 : RD_LAT + 2);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_en_pulses"}, 32'(en_seen), 32'(v.exp_en));
    e = exp_q.pop_front();
    check({tag, "_rdata"}, bus.resp_rdata, e.exp_rdata);
    check({tag, "_ale"}, 32'(bus.resp_ale), 32'(e.exp_ale));
    held = bus.resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
      check({tag, "_hold_rdata"}, bus.resp_rdata, held);
      check({tag, "_hold_req_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    // Expected values for the SRAM image 0x1000=8899AABB, 0x1004=11223344.
    vecs[0]  = mk(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'h8899AABB, 1'b0, 1'b1, 4'h0, 32'h1000, 32'h0);
    vecs[1]  = mk(1'b0, 2'd0, 1'b0, 32'h1002, 32'h0, 32'hFFFFFF99, 1'b0, 1'b1, 4'h0, 32'h1000, 32'h0);
    vecs[2]  = mk(1'b0, 2'd0, 1'b1, 32'h1002, 32'h0, 32'h00000099, 1'b0, 1'b1, 4'h0, 32'h1000, 32'h0);
    vecs[3]  = mk(1'b0, 2'd1, 1'b0, 32'h1002, 32'h0, 32'hFFFF8899, 1'b0, 1'b1, 4'h0, 32'h1000, 32'h0);
    vecs[4]  = mk(1'b0, 2'd1, 1'b1, 32'h1000, 32'h0, 32'h0000AABB, 1'b0, 1'b1, 4'h0, 32'h1000, 32'h0);
    vecs[5]  = mk(1'b0, 2'd0, 1'b0, 32'h1001, 32'h0, 32'hFFFFFFAA, 1'b0, 1'b1, 4'h0, 32'h1000, 32'h0);
    vecs[6]  = mk(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h00000088, 1'b0, 1'b1, 4'h0, 32'h1000, 32'h0);
    vecs[7]  = mk(1'b1, 2'd0, 1'b0, 32'h1003, 32'h000000C3, 32'h0, 1'b0, 1'b1, 4'b1000, 32'h1000, 32'hC3C3C3C3);
    vecs[8]  = mk(1'b1, 2'd1, 1'b0, 32'h1000, 32'h00001234, 32'h0, 1'b0, 1'b1, 4'b0011, 32'h1000, 32'h12341234);
    vecs[9]  = mk(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'hC3991234, 1'b0, 1'b1, 4'h0, 32'h1000, 32'h0);
    vecs[10] = mk(1'b0, 2'd3, 1'b0, 32'h1000, 32'h0, 32'hC3991234, 1'b0, 1'b1, 4'h0, 32'h1000, 32'h0);
    vecs[11] = mk(1'b1, 2'd2, 1'b0, 32'h1004, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 4'b1111, 32'h1004, 32'hDEADBEEF);
    vecs[12] = mk(1'b0, 2'd1, 1'b0, 32'h1006, 32'h0, 32'hFFFFDEAD, 1'b0, 1'b1, 4'h0, 32'h1004, 32'h0);
    vecs[13] = mk(1'b0, 2'd0, 1'b0, 32'h1004, 32'h0, 32'hFFFFFFEF, 1'b0, 1'b1, 4'h0, 32'h1004, 32'h0);
`ifdef LSU_ALE_EN
    vecs[14] = mk(1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    vecs[15] = mk(1'b1, 2'd1, 1'b0, 32'h1005, 32'h00005566, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    vecs[16] = mk(1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 4'h0, 32'h1004, 32'h0);
`else
    vecs[14] = mk(1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, 32'hC3991234, 1'b0, 1'b1, 4'h0, 32'h1000, 32'h0);
    vecs[15] = mk(1'b1, 2'd1, 1'b0, 32'h1005, 32'h00005566, 32'h0, 1'b0, 1'b1, 4'b0011, 32'h1004, 32'h55665566);
    vecs[16] = mk(1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, 32'hDEAD5566, 1'b0, 1'b1, 4'h0, 32'h1004, 32'h0);
`endif

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_ale", 32'(bus.resp_ale), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_sram_en", 32'(sram_en), 32'd0);
    check("rst_sram_we", 32'(sram_we), 32'd0);
    check("rst_sram_addr", sram_addr, 32'd0);
    check("rst_sram_wdata", sram_wdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      do_txn($sformatf("v%0d", i), vecs[i], 0);
    end

    // Backpressure: response held for 5 cycles.
    do_txn("bp", vecs[16], 5);

    // Reset during ACCESS of a store: strobes drop at once.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h1000; bus.req_wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst_st_en_pre", 32'(sram_en), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_st_en", 32'(sram_en), 32'd0);
    check("rst_st_we", 32'(sram_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset during WAIT of a load: no response, idle outputs immediately.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_size = 2'd2;
    bus.req_addr = 32'h1000; bus.req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_ld_busy_pre", 32'(bus.req_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_ld_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_ld_en", 32'(sram_en), 32'd0);
    check("rst_ld_we", 32'(sram_we), 32'd0);
    check("rst_ld_addr", sram_addr, 32'd0);
    check("rst_ld_wdata", sram_wdata, 32'd0);
    check("rst_ld_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < RD_LAT + 4; c++) begin
      @(negedge clk);
      check($sformatf("rst_no_resp_c%0d", c), 32'(bus.resp_valid), 32'd0);
    end

    // First request after reset completes normally on the reloaded image.
    do_txn("post_rst", vecs[0], 0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
